// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit saturating counter type, its constants,
// the update function, the PHT FSM states and the index width used by gshare.
package bp_pkg;

    localparam int BP_G_WIDTH = 7;

    typedef logic [1:0] pht_ctr_t;

    localparam pht_ctr_t CTR_SNT = 2'b00;
    localparam pht_ctr_t CTR_WNT = 2'b01;
    localparam pht_ctr_t CTR_STK = 2'b11;

    typedef enum logic {
        PHT_INIT,
        PHT_READY
    } pht_state_t;

    // Saturates at both ends instead of wrapping.
    function automatic pht_ctr_t sat_update(pht_ctr_t c, logic taken);
        pht_ctr_t r;
        if (taken) begin
            r = (c == CTR_STK) ? CTR_STK : pht_ctr_t'(c + 2'd1);
        end else begin
            r = (c == CTR_SNT) ? CTR_SNT : pht_ctr_t'(c - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/pht_ram.sv
// Counter storage for the pattern history table: one write port and two
// synchronous read ports (lookup and update read-modify-write).
module pht_ram
    import bp_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pht_ctr_t      wdata,
    input  logic [AW-1:0] raddr_a,
    output pht_ctr_t      rdata_a,
    input  logic [AW-1:0] raddr_b,
    output pht_ctr_t      rdata_b
);

    pht_ctr_t mem [2**AW];

    // Reads return the value from before a same-edge write; the parent bypasses.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_a <= mem[raddr_a];
        rdata_b <= mem[raddr_b];
    end

endmodule

// File: rtl/pattern_history_table.sv
// gshare pattern history table: initialisation sweep FSM, one-cycle lookup and a
// two-stage read-modify-write update pipeline with forwarding and lookup bypass.
module pattern_history_table
    import bp_pkg::*;
#(
    parameter int G_WIDTH = BP_G_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pred_valid,
    input  logic [G_WIDTH:0] pred_index,
    output logic             pred_ready,
    output logic             pred_out_valid,
    output logic             pred_taken,
    output logic [1:0]       pred_counter,
    input  logic             upd_valid,
    input  logic [G_WIDTH:0] upd_index,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             init_done
);

    localparam int IW = G_WIDTH + 1;

    pht_state_t       state;
    pht_state_t       next_state;
    logic [G_WIDTH:0] sweep_ptr;

    logic             pred_accept;
    logic             upd_accept;

    logic             u2_valid;
    logic [G_WIDTH:0] u2_index;
    logic             u2_taken;
    logic             u2_fwd;
    pht_ctr_t         u2_fwd_ctr;
    pht_ctr_t         u2_ctr;
    pht_ctr_t         u2_new;

    logic             pred_byp;
    pht_ctr_t         pred_byp_ctr;

    pht_ctr_t         rd_pred;
    pht_ctr_t         rd_upd;
    logic             ram_we;
    logic [G_WIDTH:0] ram_waddr;
    pht_ctr_t         ram_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= PHT_INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pred_ready = 1'b0;
        upd_ready  = 1'b0;
        init_done  = 1'b0;
        case (state)
            PHT_INIT: begin
                if (&sweep_ptr) begin
                    next_state = PHT_READY;
                end
            end
            PHT_READY: begin
                pred_ready = 1'b1;
                upd_ready  = 1'b1;
                init_done  = 1'b1;
            end
            default: next_state = PHT_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sweep_ptr <= '0;
        end else if (state == PHT_INIT) begin
            sweep_ptr <= sweep_ptr + IW'(1);
        end
    end

    assign pred_accept = pred_valid & pred_ready;
    assign upd_accept  = upd_valid & upd_ready;

    // U1 -> U2 registers; forwarding captures the value U2 writes on the same edge U1 reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            u2_valid   <= 1'b0;
            u2_index   <= '0;
            u2_taken   <= 1'b0;
            u2_fwd     <= 1'b0;
            u2_fwd_ctr <= CTR_SNT;
        end else begin
            u2_valid   <= upd_accept;
            u2_index   <= upd_index;
            u2_taken   <= upd_taken;
            u2_fwd     <= u2_valid && (u2_index == upd_index);
            u2_fwd_ctr <= u2_new;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_out_valid <= 1'b0;
            pred_byp       <= 1'b0;
            pred_byp_ctr   <= CTR_SNT;
        end else begin
            pred_out_valid <= pred_accept;
            pred_byp       <= u2_valid && (u2_index == pred_index);
            pred_byp_ctr   <= u2_new;
        end
    end

    always_comb begin
        u2_ctr       = u2_fwd ? u2_fwd_ctr : rd_upd;
        u2_new       = sat_update(u2_ctr, u2_taken);
        pred_counter = CTR_SNT;
        if (pred_out_valid) begin
            pred_counter = pred_byp ? pred_byp_ctr : rd_pred;
        end
        pred_taken = pred_counter[1];
    end

    // Sweep owns the write port during INIT; afterwards U2 does.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = u2_index;
        ram_wdata = u2_new;
        if (state == PHT_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = sweep_ptr;
            ram_wdata = CTR_WNT;
        end else if (u2_valid) begin
            ram_we = 1'b1;
        end
    end

    pht_ram #(
        .AW(IW)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .raddr_a(pred_index),
        .rdata_a(rd_pred),
        .raddr_b(upd_index),
        .rdata_b(rd_upd)
    );

endmodule

// File: tb/tb_pattern_history_table.sv
// Scoreboard bench for pattern_history_table: a reference counter array predicts
// every lookup result, which is queued at issue and compared when it comes out.
module tb_pattern_history_table;

    localparam int G = 7;
    localparam int N = 2**(G+1);

    logic         clk;
    logic         reset_n;
    logic         pred_valid;
    logic [G:0]   pred_index;
    logic         pred_ready;
    logic         pred_out_valid;
    logic         pred_taken;
    logic [1:0]   pred_counter;
    logic         upd_valid;
    logic [G:0]   upd_index;
    logic         upd_taken;
    logic         upd_ready;
    logic         init_done;

    int compared;
    int mismatched;
    int model [N];
    int exp_q [$];

    pattern_history_table #(.G_WIDTH(G)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pred_valid    (pred_valid),
        .pred_index    (pred_index),
        .pred_ready    (pred_ready),
        .pred_out_valid(pred_out_valid),
        .pred_taken    (pred_taken),
        .pred_counter  (pred_counter),
        .upd_valid     (upd_valid),
        .upd_index     (upd_index),
        .upd_taken     (upd_taken),
        .upd_ready     (upd_ready),
        .init_done     (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int model_sat(int c, bit t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) model[i] = 1;
        exp_q.delete();
    endtask

    task automatic check_zero_outputs();
        check_output("rst_init_done", init_done, 0);
        check_output("rst_pred_ready", pred_ready, 0);
        check_output("rst_upd_ready", upd_ready, 0);
        check_output("rst_pred_out_valid", pred_out_valid, 0);
        check_output("rst_pred_counter", pred_counter, 0);
        check_output("rst_pred_taken", pred_taken, 0);
    endtask

    // Called on a negedge right after reset_n is released.
    task automatic wait_init();
        repeat (N - 1) @(posedge clk);
        #1;
        check_output("init_done_early", init_done, 0);
        check_output("pred_ready_early", pred_ready, 0);
        check_output("upd_ready_early", upd_ready, 0);
        check_output("init_out_valid", pred_out_valid, 0);
        @(posedge clk);
        #1;
        check_output("init_done_on_time", init_done, 1);
        check_output("pred_ready_on_time", pred_ready, 1);
        check_output("upd_ready_on_time", upd_ready, 1);
        check_output("init_out_valid_last", pred_out_valid, 0);
        @(negedge clk);
    endtask

    // One cycle: lookup sees all updates issued in earlier cycles.
    task automatic apply_stimulus(input bit pv, input int pi, input bit uv, input int ui, input bit ut);
        int e;
        pred_valid = pv;
        pred_index = pi[G:0];
        upd_valid  = uv;
        upd_index  = ui[G:0];
        upd_taken  = ut;
        if (pv) exp_q.push_back(model[pi]);
        if (uv) model[ui] = model_sat(model[ui], ut);
        @(posedge clk);
        #1;
        check_output("pred_out_valid", pred_out_valid, pv);
        if (pv) begin
            e = exp_q.pop_front();
            check_output("pred_counter", pred_counter, e);
            check_output("pred_taken", pred_taken, e[1]);
        end
        @(negedge clk);
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n    = 1'b0;
        pred_valid = 1'b0;
        pred_index = '0;
        upd_valid  = 1'b0;
        upd_index  = '0;
        upd_taken  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero_outputs();

        // Requests during INIT must be ignored.
        reset_n    = 1'b1;
        pred_valid = 1'b1;
        pred_index = 8'h3A;
        upd_valid  = 1'b1;
        upd_index  = 8'h3A;
        upd_taken  = 1'b1;
        wait_init();
        pred_valid = 1'b0;
        upd_valid  = 1'b0;

        apply_stimulus(1, 'h3A, 0, 0, 0);
        apply_stimulus(0, 0, 1, 'h3A, 1);
        apply_stimulus(0, 0, 1, 'h3A, 1);
        apply_stimulus(0, 0, 1, 'h3A, 1);
        apply_stimulus(1, 'h3A, 0, 0, 0);
        apply_stimulus(0, 0, 1, 'h3A, 1);
        apply_stimulus(1, 'h3A, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);

        apply_stimulus(0, 0, 1, 'h05, 0);
        apply_stimulus(0, 0, 1, 'h05, 0);
        apply_stimulus(1, 'h05, 0, 0, 0);
        apply_stimulus(1, 'h05, 1, 'h05, 0);

        apply_stimulus(1, 'h20, 1, 'h20, 1);
        apply_stimulus(1, 'h20, 0, 0, 0);

        for (int i = 0; i < 64; i++) begin
            apply_stimulus(0, 0, 1, (i % 2 == 0) ? 'h10 : 'h11, (i % 2 == 0));
        end
        apply_stimulus(1, 'h10, 0, 0, 0);
        apply_stimulus(1, 'h11, 0, 0, 0);
        check_output("model_0x10_sat", model['h10], 3);
        check_output("model_0x11_sat", model['h11], 0);

        // Reset with a lookup result showing and an update in flight.
        pred_valid = 1'b1;
        pred_index = 8'h3A;
        upd_valid  = 1'b1;
        upd_index  = 8'h3A;
        upd_taken  = 1'b0;
        @(posedge clk);
        #1;
        check_output("pre_reset_valid", pred_out_valid, 1);
        check_output("pre_reset_counter", pred_counter, model['h3A]);
        reset_n = 1'b0;
        #1;
        check_zero_outputs();
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        @(negedge clk);

        // Reset again with the sweep part-way through (entry 100).
        reset_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_zero_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        wait_init();
        model_reset();

        apply_stimulus(1, 'h3A, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            apply_stimulus($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                           $urandom_range(0, 7), $urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1, i, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
